// File: rtl/if_prefetch_pkg.sv
// Shared fetch/decode definitions: opcodes, type codes
// and the {IR, NPC} entry carried from IF to ID.
package if_prefetch_pkg;

  localparam int DEF_ADDR_W = 10;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef enum logic [2:0] {
    RR_ALU = 3'd0,
    RM_ALU = 3'd1,
    LOAD   = 3'd2,
    STORE  = 3'd3,
    BRANCH = 3'd4,
    HALT   = 3'd5
  } instr_type_e;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } fetch_entry_t;

  function automatic logic is_hlt(
    input logic [31:0] ir
  );
    return ir[31:26] == OP_HLT;
  endfunction

endpackage

// File: rtl/if_prefetch_if.sv
// IF bus bundle: instruction-memory read port plus
// the valid/ready handoff toward ID.
interface if_prefetch_if
  import if_prefetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              id_valid;
  logic              id_ready;
  logic [31:0]       id_ir;
  logic [31:0]       id_npc;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    output id_valid,
    input  id_ready,
    output id_ir,
    output id_npc
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    input  id_valid,
    output id_ready,
    input  id_ir,
    input  id_npc
  );
endinterface

// File: rtl/if_prefetch_fetch_fifo.sv
// Prefetch queue of fetch entries; flush wins over push
// and pop in the same cycle.
module fetch_fifo
  import if_prefetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  fetch_entry_t data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t data_o,
  output logic [CW-1:0] count_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  assign do_push = push_i && !flush_i && !full_o;
  assign do_pop  = pop_i && !flush_i && !empty_o;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_pop)  rd_d = rd_q + PW'(1);
      if (do_push && !do_pop) cnt_d = cnt_q + CW'(1);
      if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: issues word reads, queues
// {IR, NPC} pairs for ID, handles redirect/halt/HLT.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic              clk1,
  input  logic              rst,
  if_prefetch_if.master     bus,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              halted
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] RST_PC =
    ADDR_W'(RESET_PC);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_STOP = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              inflight_q, inflight_d;

  logic              redir, flush;
  logic              req, push, pop, hlt_push;
  logic [ADDR_W-1:0] npc_addr;
  logic [CW:0]       used;
  logic [CW-1:0]     count;
  logic              fifo_full, fifo_empty;
  fetch_entry_t      entry, head;

  assign redir = redirect_valid && state_q != ST_HALT;
  assign flush = halt || redir;

  // Credit counts the outstanding response; same-cycle pops do not free a slot.
  assign used = {1'b0, count} + (CW+1)'(inflight_q);
  assign req  = !rst && state_q == ST_RUN && !flush
             && !fifo_full && used < (CW+1)'(DEPTH);

  assign npc_addr  = raddr_q + ADDR_W'(1);
  assign entry.ir  = bus.imem_rdata;
  assign entry.npc = 32'(npc_addr);

  assign push     = inflight_q && !flush;
  assign pop      = bus.id_valid && bus.id_ready && !flush;
  assign hlt_push = push && is_hlt(bus.imem_rdata);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    raddr_d    = raddr_q;
    inflight_d = req;
    if (req) begin
      pc_d    = pc_q + ADDR_W'(1);
      raddr_d = pc_q;
    end
    // The request issued alongside the HLT response is dropped here.
    if (hlt_push) begin
      state_d    = ST_STOP;
      pc_d       = npc_addr;
      inflight_d = 1'b0;
    end
    if (redir) begin
      state_d    = ST_RUN;
      pc_d       = redirect_pc;
      inflight_d = 1'b0;
    end
    if (halt) begin
      state_d    = ST_HALT;
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RST_PC;
      raddr_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      raddr_q    <= raddr_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk1),
    .rst     (rst),
    .push_i  (push),
    .data_i  (entry),
    .pop_i   (pop),
    .flush_i (flush),
    .data_o  (head),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.imem_req  = req;
  assign bus.imem_addr = req ? pc_q : '0;
  assign bus.id_valid  = !fifo_empty;
  assign bus.id_ir     = fifo_empty ? '0 : head.ir;
  assign bus.id_npc    = fifo_empty ? '0 : head.npc;
  assign halted        = state_q == ST_HALT;

endmodule
